// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster timing block.
// Holds the 640x480@60 defaults, the derived totals and sync windows, the
// coordinate width, and a small range helper used by the sync decoders.
package vga_pkg;
  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  // Inclusive range test on a coordinate.
  function automatic logic in_span(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Renderer / connector bundle for vga_timing_gen.
// master: the timing generator (drives scan position, strobes, sync, rgb;
//         receives renderer colour).  slave: the renderer/connector side.
interface vga_timing_gen_if;
  import vga_pkg::*;
  coord_t x_crd;
  coord_t y_crd;
  logic   pix_tick;
  logic   frame_start;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   red_ch, green_ch, blue_ch;
  logic   red_out, green_out, blue_out;

  modport master (
    input  red_ch, green_ch, blue_ch,
    output x_crd, y_crd, pix_tick, frame_start, hsync, vsync, video_on,
           red_out, green_out, blue_out
  );
  modport slave (
    output red_ch, green_ch, blue_ch,
    input  x_crd, y_crd, pix_tick, frame_start, hsync, vsync, video_on,
           red_out, green_out, blue_out
  );
endinterface

// File: rtl/vga_pixel_tick.sv
// Pixel-rate strobe: one-clk enable every CLK_DIV clocks (1..15).
// Ports: clk, rst_n (sync, active-low), tick (registered enable, not a clock).
// The strobe is registered from the next count so it is glitch-free and is
// held low through reset even when CLK_DIV=1.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 defaults from a 100 MHz clock).
// Ports: clk, rst_n (sync, active-low), vif (vga_timing_gen_if.master):
//   scan position x_crd/y_crd and pix_tick/frame_start to the renderer,
//   renderer colour in, and registered hsync/vsync/video_on/rgb out.
// Output stage has one pixel of latency so sync, video_on and rgb all
// describe the same pixel.
// Build option VGA_BORDER_EN: white one-pixel frame around the visible area.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vif
);
  localparam int     HT     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     VT     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int     HS_LO  = H_VISIBLE + H_FRONT;
  localparam int     HS_HI  = HS_LO + H_SYNC - 1;
  localparam int     VS_LO  = V_VISIBLE + V_FRONT;
  localparam int     VS_HI  = VS_LO + V_SYNC - 1;
  localparam coord_t X_LAST = coord_t'(HT - 1);
  localparam coord_t Y_LAST = coord_t'(VT - 1);

  logic   pix_tick;
  coord_t x_q, x_d, y_q, y_d;
  logic   fs_q, fs_d, hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic [2:0] rgb_q, rgb_d;
  logic   vis, border;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (pix_tick)
  );

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    hs_d  = hs_q;
    vs_d  = vs_q;
    von_d = von_q;
    rgb_d = rgb_q;
    // Decoded on the pre-increment position: the pixel being sampled now.
    vis   = (int'(x_q) < H_VISIBLE) && (int'(y_q) < V_VISIBLE);
`ifdef VGA_BORDER_EN
    border = vis && ((x_q == '0) || (int'(x_q) == H_VISIBLE - 1) ||
                     (y_q == '0) || (int'(y_q) == V_VISIBLE - 1));
`else
    border = 1'b0;
`endif
    if (pix_tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
      von_d = vis;
      // AND with vis forces zero in blanking even if the renderer drives junk.
      rgb_d = ({vif.red_ch, vif.green_ch, vif.blue_ch} & {3{vis}}) | {3{border}};
      hs_d  = ~in_span(x_q, HS_LO, HS_HI);
      vs_d  = ~in_span(y_q, VS_LO, VS_HI);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
      rgb_q <= 3'b000;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      rgb_q <= rgb_d;
    end
  end

  assign vif.x_crd       = x_q;
  assign vif.y_crd       = y_q;
  assign vif.pix_tick    = pix_tick;
  assign vif.frame_start = fs_q;
  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.video_on    = von_q;
  assign vif.red_out     = rgb_q[2];
  assign vif.green_out   = rgb_q[1];
  assign vif.blue_out    = rgb_q[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (34x19 pixels, CLK_DIV=3)
// so many frames fit in a short run. The model derives every output from the
// number of clocks since reset by plain division/modulo.
module tb_vga_timing_gen;
  localparam int D  = 3;
  localparam int HV = 20, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 34
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FR = HT * VT;             // 646 pixels per frame

  logic clk = 1'b0;
  logic rst_n;
  logic started = 1'b0;
  int   t = 0;                 // clocks since the last reset edge
  int   checks = 0, errors = 0;
  logic [2:0] pat [FR];        // renderer image, random per run
  int   ridx;

  always #5 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  // Renderer: colour is a pure function of the current scan position.
  assign ridx = int'(vif.y_crd) * HT + int'(vif.x_crd);
  assign vif.red_ch   = (ridx < FR) ? pat[ridx][2] : 1'b0;
  assign vif.green_ch = (ridx < FR) ? pat[ridx][1] : 1'b0;
  assign vif.blue_ch  = (ridx < FR) ? pat[ridx][0] : 1'b0;

  always @(posedge clk) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // Expected outputs after tt clocks out of reset, packed as
  // {x, y, tick, frame_start, hsync, vsync, video_on, r, g, b}.
  function automatic logic [27:0] model(input int tt);
    int p, x, y, q, qx, qy;
    logic tick, fs, hs, vs, von, vis, brd;
    logic [2:0] rgb;
    p    = tt / D;
    x    = p % HT;
    y    = (p / HT) % VT;
    tick = (tt >= 1) && ((tt + 1) % D == 0);
    fs   = (tt > 0) && (tt % D == 0) && (p % FR == 0);
    if (p == 0) begin
      hs = 1'b1; vs = 1'b1; von = 1'b0; rgb = 3'b000;
    end else begin
      q   = p - 1;
      qx  = q % HT;
      qy  = (q / HT) % VT;
      vis = (qx < HV) && (qy < VV);
      brd = 1'b0;
`ifdef VGA_BORDER_EN
      brd = vis && (qx == 0 || qx == HV - 1 || qy == 0 || qy == VV - 1);
`endif
      von = vis;
      rgb = (pat[qy * HT + qx] & {3{vis}}) | {3{brd}};
      hs  = !(qx >= HV + HF && qx < HV + HF + HS);
      vs  = !(qy >= VV + VF && qy < VV + VF + VS);
    end
    return {10'(x), 10'(y), tick, fs, hs, vs, von, rgb};
  endfunction

  // Cycle-by-cycle comparison against the model.
  logic [27:0] act_v, exp_v;
  always @(negedge clk) begin
    if (started) begin
      act_v = {vif.x_crd, vif.y_crd, vif.pix_tick, vif.frame_start, vif.hsync,
               vif.vsync, vif.video_on, vif.red_out, vif.green_out, vif.blue_out};
      exp_v = model(t);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs: got %h expected %h (t=%0d)", act_v, exp_v, t);
      end
    end
  end

  // Hand-derived interval checks: hsync 6 px * 3 clk, vsync 2 lines,
  // frame 646 px * 3 clk, 20x12 visible px * 3 clk of video_on per frame.
  int hl = 0, vl = 0, fgap = -1, von_cnt = 0;
  logic hok = 1'b0, vok = 1'b0;
  always @(negedge clk) begin
    if (!started || t == 0) begin
      hl = 0; vl = 0; hok = 1'b0; vok = 1'b0; fgap = -1; von_cnt = 0;
    end else begin
      if (!vif.hsync) hl++;
      else begin
        if (hl > 0 && hok) chk("hsync_low_clks", hl, 18);
        hl = 0; hok = 1'b1;
      end
      if (!vif.vsync) vl++;
      else begin
        if (vl > 0 && vok) chk("vsync_low_clks", vl, 2 * HT * D);
        vl = 0; vok = 1'b1;
      end
      if (fgap >= 0) begin
        fgap++;
        if (vif.video_on) von_cnt++;
      end
      if (vif.frame_start) begin
        if (fgap >= 0) begin
          chk("frame_gap_clks", fgap, 1938);
          chk("video_on_clks", von_cnt, 720);
        end
        fgap = 0; von_cnt = 0;
      end
    end
  end

  initial begin
    bit found;
    foreach (pat[i]) pat[i] = 3'($urandom);
    rst_n = 1'b0;
    @(posedge clk);
    started = 1'b1;
    repeat (9) @(negedge clk);
    chk("reset_x", int'(vif.x_crd), 0);
    chk("reset_y", int'(vif.y_crd), 0);
    chk("reset_tick", int'(vif.pix_tick), 0);
    chk("reset_hsync", int'(vif.hsync), 1);
    chk("reset_vsync", int'(vif.vsync), 1);
    chk("reset_rgb", int'({vif.red_out, vif.green_out, vif.blue_out}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("first_tick", int'(vif.pix_tick), 1);
    chk("x_before_tick", int'(vif.x_crd), 0);
    @(negedge clk);
    chk("x_after_tick", int'(vif.x_crd), 1);
    chk("tick_drop", int'(vif.pix_tick), 0);

    repeat (3 * FR * D) @(negedge clk);

    // Reset in the middle of an hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (!vif.hsync && vif.y_crd == 10'd5) found = 1'b1;
    end
    chk("wait_hsync_low", int'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_hsync", int'(vif.hsync), 1);
    chk("midreset_x", int'(vif.x_crd), 0);
    chk("midreset_y", int'(vif.y_crd), 0);
    rst_n = 1'b1;
    repeat (2 * FR * D) @(negedge clk);

    // Random short resets at random points in the frame.
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(50, 2500)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (2 * FR * D + 50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
